// File: rtl/lap_timer.sv
// mm:ss stopwatch / countdown timer with a clock-enable tick, lap buffer and lap recall.
// Drives four BCD digits {m1,m0,s1,s0}; pulse inputs are single-cycle debounced strobes.
module lap_timer #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MAX_MIN   = 59
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pb_start,
  input  logic                         pb_lap,
  input  logic                         pb_clr,
  input  logic                         mode_down,
  input  logic [15:0]                  preset,
  output logic [15:0]                  disp,
  output logic [1:0]                   disp_src,
  output logic [$clog2(LAP_DEPTH)-1:0] lap_idx,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_full,
  output logic                         running,
  output logic                         done,
  output logic                         ovf
);

  localparam int unsigned LW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [LW:0]   DEPTH     = (LW+1)'(LAP_DEPTH);
  localparam logic [15:0]   WRAP_TIME = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 8'h59};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAP_HOLD, S_PAUSE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    time_q, time_d, disp_q, disp_d, idle_time;
  logic [15:0]    lap_ram [LAP_DEPTH];
  logic [CW-1:0]  presc_q, presc_d;
  logic [LW:0]    count_q, count_d;
  logic [LW-1:0]  idx_q, idx_d;
  logic           recall_q, recall_d, mode_q, mode_d, done_q, done_d, ovf_q, ovf_d, full_q;
  logic           counting, tick, capture, lap_we;

  function automatic logic [15:0] up_step(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  function automatic logic [15:0] down_step(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Value shown while idle: zero for count-up, clamped preset for countdown.
  assign idle_time = mode_down ?
                     {preset[15:8], ((preset[7:4] > 4'd5) ? 4'd5 : preset[7:4]), preset[3:0]} :
                     16'h0000;

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    presc_d  = presc_q;
    disp_d   = time_q;
    count_d  = count_q;
    idx_d    = idx_q;
    recall_d = recall_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    capture  = 1'b0;
    lap_we   = 1'b0;
    counting = (state_q == S_RUN) || (state_q == S_LAP_HOLD);
    tick     = counting && (presc_q == TICK_LAST);

    if (counting) presc_d = tick ? '0 : presc_q + CW'(1);

    if (tick) begin
      if (mode_q) begin
        if (time_q <= 16'h0001) begin
          time_d  = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          time_d = down_step(time_q);
        end
      end else if (time_q == WRAP_TIME) begin
        time_d = '0;
        ovf_d  = 1'b1;
      end else begin
        time_d = up_step(time_q);
      end
    end

    if (state_q == S_LAP_HOLD || (state_q == S_PAUSE && recall_q)) disp_d = disp_q;

    if (pb_clr) begin
      state_d  = S_IDLE;
      time_d   = idle_time;
      disp_d   = idle_time;
      presc_d  = '0;
      count_d  = '0;
      idx_d    = '0;
      recall_d = 1'b0;
      ovf_d    = 1'b0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          time_d = idle_time;
          mode_d = mode_down;
          if (pb_start) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: if (state_d != S_DONE) begin
          if (pb_start) state_d = S_PAUSE;
          else if (pb_lap) begin
            state_d = S_LAP_HOLD;
            capture = 1'b1;
          end
        end
        S_LAP_HOLD: if (state_d != S_DONE) begin
          if (pb_start) state_d = S_PAUSE;
          else if (pb_lap) begin
            state_d = S_RUN;
            capture = 1'b1;
          end
        end
        S_PAUSE: begin
          if (pb_start) begin
            state_d  = S_RUN;
            recall_d = 1'b0;
          end else if (pb_lap && count_q != '0) begin
            recall_d = 1'b1;
            idx_d    = (!recall_q || {1'b0, idx_q} == count_q - (LW+1)'(1)) ? '0 : idx_q + LW'(1);
            disp_d   = lap_ram[idx_d];
          end
        end
        default: ;
      endcase
    end

    // Capture uses the pre-tick time; a full buffer still toggles the freeze.
    if (capture) begin
      disp_d = time_q;
      if (count_q != DEPTH) begin
        lap_we  = 1'b1;
        count_d = count_q + (LW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      time_q   <= '0;
      presc_q  <= '0;
      disp_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      recall_q <= 1'b0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      disp_q   <= disp_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      recall_q <= recall_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      full_q   <= (count_d == DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (lap_we) lap_ram[count_q[LW-1:0]] <= time_q;
  end

  assign disp      = disp_q;
  assign lap_idx   = idx_q;
  assign lap_count = count_q;
  assign lap_full  = full_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign running   = (state_q == S_RUN) || (state_q == S_LAP_HOLD);
  assign disp_src  = (state_q == S_LAP_HOLD)            ? 2'd1 :
                     (state_q == S_PAUSE && recall_q)   ? 2'd2 : 2'd0;

endmodule
